// File: rtl/spi_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// spi_cmd_sequencer
//   Transaction controller for the PWM IO expander SPI slave. Turns per-byte
//   strobes from the SPI shifter into command / address / data phases. It
//   drives register-file write and read strobes and loads the SPI transmit
//   byte for reads.
//
//   Build option: define ADDR_AUTOINC_EN to enable burst transfers. RegAddr
//   then advances after every data strobe and wraps from NUM_REGS-1 to 0.
//   Without it, each transaction carries one data byte, and extra bytes
//   raise ErrFlag.
//
// Ports
//   CLK        in   system clock, posedge
//   _RST       in   asynchronous active-low reset
//   _CS        in   chip select (synchronised), high = idle
//   ByteValid  in   one-cycle pulse, RxByte holds a complete byte
//   RxByte     in   received byte
//   RegRdData  in   register read data, combinational from RegAddr
//   RegAddr    out  register address
//   RegWrData  out  register write data
//   RegWrEn    out  one-cycle write strobe
//   RegRdEn    out  one-cycle read strobe
//   TxByte     out  byte for the shifter's next slot
//   TxLoad     out  one-cycle pulse, TxByte updated
//   Busy       out  high whenever not IDLE
//   ErrFlag    out  sticky illegal-access flag, cleared when CMD is entered
// ---------------------------------------------------------------------------
module spi_cmd_sequencer #(
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 12
) (
    input  logic              CLK,
    input  logic              _RST,
    input  logic              _CS,
    input  logic              ByteValid,
    input  logic [7:0]        RxByte,
    input  logic [7:0]        RegRdData,
    output logic [ADDR_W-1:0] RegAddr,
    output logic [7:0]        RegWrData,
    output logic              RegWrEn,
    output logic              RegRdEn,
    output logic [7:0]        TxByte,
    output logic              TxLoad,
    output logic              Busy,
    output logic              ErrFlag
);

`ifdef ADDR_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NREGS     = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wrdata_q, wrdata_d;
    logic                wren_q, wren_d;
    logic                rden_q, rden_d;
    logic [7:0]          txbyte_q, txbyte_d;
    logic                txload_q, txload_d;
    logic                err_q, err_d;
    logic                rdpend_q, rdpend_d;  // TxByte load due next cycle
    logic                rdzero_q, rdzero_d;  // that load sends 8'h00
    logic                adv_q, adv_d;        // address advance due next cycle
    logic                seen_q, seen_d;      // data byte already consumed

    // Command bits [6:ADDR_W] carry no meaning.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^RxByte[6:ADDR_W];

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NREGS;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    // State register
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic. A byte that arrives together with the _CS rise is
    // still decoded. The drop to IDLE happens on the following cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!_CS) state_d = S_CMD;
            S_CMD: begin
                if (ByteValid)  state_d = RxByte[7] ? S_RDATA : S_WDATA;
                else if (_CS)   state_d = S_IDLE;
            end
            S_WDATA, S_RDATA: if (_CS && !ByteValid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values. The first stage runs on the ByteValid edge and
    // issues strobes. The second stage, one cycle later, loads TxByte from
    // RegRdData at the strobed address and then advances the address.
    always_comb begin
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        txbyte_d = txbyte_q;
        txload_d = 1'b0;
        err_d    = err_q;
        rdpend_d = 1'b0;
        rdzero_d = 1'b0;
        adv_d    = 1'b0;
        seen_d   = seen_q;

        if (rdpend_q) begin
            txbyte_d = rdzero_q ? 8'h00 : RegRdData;
            txload_d = 1'b1;
        end
        if (adv_q) addr_d = next_addr(addr_q);

        if (state_q == S_IDLE && !_CS) begin
            err_d  = 1'b0;
            seen_d = 1'b0;
        end

        if (ByteValid) begin
            case (state_q)
                S_CMD: begin
                    addr_d = RxByte[ADDR_W-1:0];
                    if (RxByte[7]) begin
                        rden_d   = addr_ok(RxByte[ADDR_W-1:0]);
                        rdpend_d = 1'b1;
                        rdzero_d = !addr_ok(RxByte[ADDR_W-1:0]);
                        adv_d    = AUTOINC;
                        if (!addr_ok(RxByte[ADDR_W-1:0])) err_d = 1'b1;
                    end
                end
                S_WDATA: begin
                    if (AUTOINC || !seen_q) begin
                        seen_d = 1'b1;
                        adv_d  = AUTOINC;
                        if (addr_ok(addr_q)) begin
                            wren_d   = 1'b1;
                            wrdata_d = RxByte;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_RDATA: begin
                    // The command byte already fetched the first read. Without
                    // auto-increment, the first byte here closes the data slot.
                    // Any later byte is an error and reloads 8'h00.
                    if (AUTOINC) begin
                        rden_d   = addr_ok(addr_q);
                        rdpend_d = 1'b1;
                        rdzero_d = !addr_ok(addr_q);
                        adv_d    = 1'b1;
                        if (!addr_ok(addr_q)) err_d = 1'b1;
                    end else if (!seen_q) begin
                        seen_d = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        rdpend_d = 1'b1;
                        rdzero_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            addr_q   <= '0;
            wrdata_q <= 8'h00;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            txbyte_q <= 8'h00;
            txload_q <= 1'b0;
            err_q    <= 1'b0;
            rdpend_q <= 1'b0;
            rdzero_q <= 1'b0;
            adv_q    <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            txbyte_q <= txbyte_d;
            txload_q <= txload_d;
            err_q    <= err_d;
            rdpend_q <= rdpend_d;
            rdzero_q <= rdzero_d;
            adv_q    <= adv_d;
            seen_q   <= seen_d;
        end
    end

    // Output logic
    always_comb begin
        Busy      = (state_q != S_IDLE);
        RegAddr   = addr_q;
        RegWrData = wrdata_q;
        RegWrEn   = wren_q;
        RegRdEn   = rden_q;
        TxByte    = txbyte_q;
        TxLoad    = txload_q;
        ErrFlag   = err_q;
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
module tb_spi_cmd_sequencer;
    localparam int NUM_REGS = 12;
`ifdef ADDR_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       _RST = 1'b0;
    logic       _CS = 1'b1;
    logic       ByteValid = 1'b0;
    logic [7:0] RxByte = 8'h00;
    logic [7:0] RegRdData;
    logic [3:0] RegAddr;
    logic [7:0] RegWrData, TxByte;
    logic       RegWrEn, RegRdEn, TxLoad, Busy, ErrFlag;

    spi_cmd_sequencer #(.ADDR_W(4), .NUM_REGS(NUM_REGS)) dut (
        .CLK(CLK), ._RST(_RST), ._CS(_CS), .ByteValid(ByteValid), .RxByte(RxByte),
        .RegRdData(RegRdData), .RegAddr(RegAddr), .RegWrData(RegWrData),
        .RegWrEn(RegWrEn), .RegRdEn(RegRdEn), .TxByte(TxByte), .TxLoad(TxLoad),
        .Busy(Busy), .ErrFlag(ErrFlag)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Register bank seen by the DUT. Out-of-range addresses return a marker.
    logic [7:0] regs [NUM_REGS] = '{default: 8'h00};
    assign RegRdData = (int'(RegAddr) < NUM_REGS) ? regs[RegAddr] : 8'hEE;
    always @(posedge CLK)
        if (_RST && RegWrEn && int'(RegAddr) < NUM_REGS) regs[RegAddr] <= RegWrData;

    // Observed strobe events
    logic [11:0] wr_obs[$];
    logic [3:0]  rd_obs[$];
    logic [7:0]  tx_obs[$];
    int          wr_cyc[$], rd_cyc[$], tx_cyc[$];
    bit          both_seen = 1'b0;
    always @(negedge CLK) begin
        if (RegWrEn) begin wr_obs.push_back({RegAddr, RegWrData}); wr_cyc.push_back(cyc); end
        if (RegRdEn) begin rd_obs.push_back(RegAddr); rd_cyc.push_back(cyc); end
        if (TxLoad)  begin tx_obs.push_back(TxByte); tx_cyc.push_back(cyc); end
        if (RegWrEn && RegRdEn) both_seen = 1'b1;
    end

    // Reference model at the transaction level
    logic [7:0]  mregs [NUM_REGS] = '{default: 8'h00};
    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic        exp_err;
    int          bv_cyc[$];
    int          n_cmp = 0, n_fail = 0;

    function automatic logic [3:0] adv(input logic [3:0] a);
        return (int'(a) == NUM_REGS - 1) ? 4'h0 : a + 4'h1;
    endfunction

    function automatic void mread(input logic [3:0] a);
        if (int'(a) < NUM_REGS) begin
            exp_rd.push_back(a);
            exp_tx.push_back(mregs[a]);
        end else begin
            exp_err = 1'b1;
            exp_tx.push_back(8'h00);
        end
    endfunction

    function automatic void model_txn(input logic [7:0] b[$]);
        logic [3:0] a;
        exp_wr.delete(); exp_rd.delete(); exp_tx.delete(); exp_err = 1'b0;
        a = b[0][3:0];
        for (int i = 0; i < b.size(); i++) begin
            if (b[0][7]) begin
                if (AUTOINC || i == 0) mread(a);
                else if (i >= 2) begin exp_err = 1'b1; exp_tx.push_back(8'h00); end
                if (AUTOINC) a = adv(a);
            end else if (i > 0) begin
                if (AUTOINC || i == 1) begin
                    if (int'(a) < NUM_REGS) begin
                        exp_wr.push_back({a, b[i]});
                        mregs[a] = b[i];
                    end else exp_err = 1'b1;
                    if (AUTOINC) a = adv(a);
                end else exp_err = 1'b1;
            end
        end
    endfunction

    function automatic string sig(input logic [11:0] w[$], input logic [3:0] r[$],
                                  input logic [7:0] t[$], input logic e);
        string s = "";
        foreach (w[i]) s = {s, $sformatf("W%0h=%02h ", w[i][11:8], w[i][7:0])};
        foreach (r[i]) s = {s, $sformatf("R%0h ", r[i])};
        foreach (t[i]) s = {s, $sformatf("T%02h ", t[i])};
        s = {s, $sformatf("E%0b", e)};
        return s;
    endfunction

    task automatic clear_obs();
        wr_obs.delete(); rd_obs.delete(); tx_obs.delete();
        wr_cyc.delete(); rd_cyc.delete(); tx_cyc.delete(); bv_cyc.delete();
    endtask

    // Drives one transaction. If cs_last is set, _CS rises together with the last byte.
    task automatic run_txn(input logic [7:0] b[$], input bit cs_last);
        clear_obs();
        @(posedge CLK); #1; _CS = 1'b0;
        repeat (2) @(posedge CLK); #1;
        for (int i = 0; i < b.size(); i++) begin
            ByteValid = 1'b1; RxByte = b[i];
            if (cs_last && i == b.size() - 1) _CS = 1'b1;
            bv_cyc.push_back(cyc);
            @(posedge CLK); #1;
            ByteValid = 1'b0;
            repeat ($urandom_range(3, 5)) @(posedge CLK);
            #1;
        end
        _CS = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({RegAddr, RegWrData, RegWrEn, RegRdEn, TxByte, TxLoad, Busy, ErrFlag} !== '0) begin
            n_fail++;
            $display("FAIL reset_init: got addr=%h wd=%h we=%b re=%b tx=%h tl=%b busy=%b err=%b, want all 0",
                     RegAddr, RegWrData, RegWrEn, RegRdEn, TxByte, TxLoad, Busy, ErrFlag);
        end
        _RST = 1'b1;
        clear_obs();
        @(posedge CLK); #1; _CS = 1'b0;
        repeat (2) @(posedge CLK); #1;
        ByteValid = 1'b1; RxByte = 8'h03;
        @(posedge CLK); #1; ByteValid = 1'b0;
        repeat (3) @(posedge CLK); #1;
        ByteValid = 1'b1; RxByte = 8'hA5;
        #2 _RST = 1'b0;
        #1;
        n_cmp++;
        if ({RegAddr, RegWrData, RegWrEn, RegRdEn, TxByte, TxLoad, Busy, ErrFlag} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got addr=%h wd=%h we=%b re=%b tx=%h tl=%b busy=%b err=%b, want all 0",
                     RegAddr, RegWrData, RegWrEn, RegRdEn, TxByte, TxLoad, Busy, ErrFlag);
        end
        @(posedge CLK); #1; ByteValid = 1'b0; _CS = 1'b1;
        repeat (3) @(posedge CLK); #1;
        n_cmp++;
        if (wr_obs.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_nowrite: got %0d writes, want 0", wr_obs.size());
        end
        _RST = 1'b1;
        repeat (2) @(posedge CLK); #1;
    endtask

    task automatic test_write();
        logic [7:0] q[$];
        string so, se;
        q = {8'h03, 8'hA5};
        model_txn(q); run_txn(q, 1'b0);
        so = sig(wr_obs, rd_obs, tx_obs, ErrFlag); se = sig(exp_wr, exp_rd, exp_tx, exp_err);
        n_cmp++;
        if (so != se) begin n_fail++; $display("FAIL write_events: got %s want %s", so, se); end
        n_cmp++;
        if ((wr_obs.size() > 0 ? wr_obs[0] : 12'hxxx) !== 12'h3A5 || ErrFlag !== 1'b0) begin
            n_fail++; $display("FAIL write_a5: got wr=%h err=%b want 3a5 err=0",
                               wr_obs.size() > 0 ? wr_obs[0] : 12'hxxx, ErrFlag);
        end
        n_cmp++;
        if ((wr_cyc.size() > 0 ? wr_cyc[0] : -1) !== bv_cyc[1] + 1) begin
            n_fail++; $display("FAIL write_latency: got cycle %0d want %0d",
                               wr_cyc.size() > 0 ? wr_cyc[0] : -1, bv_cyc[1] + 1);
        end
    endtask

    task automatic test_read();
        logic [7:0] q[$];
        string so, se;
        q = {8'h05, 8'h5C};
        model_txn(q); run_txn(q, 1'b0);
        q = {8'h85, 8'h00};
        model_txn(q); run_txn(q, 1'b0);
        so = sig(wr_obs, rd_obs, tx_obs, ErrFlag); se = sig(exp_wr, exp_rd, exp_tx, exp_err);
        n_cmp++;
        if (so != se) begin n_fail++; $display("FAIL read_events: got %s want %s", so, se); end
        n_cmp++;
        if ((rd_obs.size() > 0 ? rd_obs[0] : 4'hx) !== 4'h5 ||
            (rd_cyc.size() > 0 ? rd_cyc[0] : -1) !== bv_cyc[0] + 1) begin
            n_fail++; $display("FAIL read_strobe: got addr=%h cyc=%0d want addr=5 cyc=%0d",
                               rd_obs.size() > 0 ? rd_obs[0] : 4'hx,
                               rd_cyc.size() > 0 ? rd_cyc[0] : -1, bv_cyc[0] + 1);
        end
        n_cmp++;
        if ((tx_obs.size() > 0 ? tx_obs[0] : 8'hxx) !== 8'h5C ||
            (tx_cyc.size() > 0 ? tx_cyc[0] : -1) !== bv_cyc[0] + 2) begin
            n_fail++; $display("FAIL read_txload: got tx=%h cyc=%0d want tx=5c cyc=%0d",
                               tx_obs.size() > 0 ? tx_obs[0] : 8'hxx,
                               tx_cyc.size() > 0 ? tx_cyc[0] : -1, bv_cyc[0] + 2);
        end
    endtask

    task automatic test_burst();
        logic [7:0] q[$];
        string so, se;
        q = {8'h0A, 8'h11, 8'h22, 8'h33};
        model_txn(q); run_txn(q, 1'b0);
        so = sig(wr_obs, rd_obs, tx_obs, ErrFlag); se = sig(exp_wr, exp_rd, exp_tx, exp_err);
        n_cmp++;
        if (so != se) begin n_fail++; $display("FAIL burst_events: got %s want %s", so, se); end
        n_cmp++;
        if (wr_obs.size() !== (AUTOINC ? 3 : 1) || ErrFlag !== !AUTOINC) begin
            n_fail++; $display("FAIL burst_count: got %0d writes err=%b want %0d err=%b",
                               wr_obs.size(), ErrFlag, AUTOINC ? 3 : 1, !AUTOINC);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] q[$];
        string so, se;
        q = {8'h0E, 8'hFF};
        model_txn(q); run_txn(q, 1'b0);
        so = sig(wr_obs, rd_obs, tx_obs, ErrFlag); se = sig(exp_wr, exp_rd, exp_tx, exp_err);
        n_cmp++;
        if (so != se || ErrFlag !== 1'b1 || wr_obs.size() !== 0) begin
            n_fail++; $display("FAIL illegal_write: got %s want %s (err=1, no write)", so, se);
        end
        @(posedge CLK); #1; _CS = 1'b0;
        repeat (2) @(posedge CLK); #1;
        n_cmp++;
        if (ErrFlag !== 1'b0) begin
            n_fail++; $display("FAIL illegal_clear: got err=%b want 0", ErrFlag);
        end
        _CS = 1'b1;
        repeat (3) @(posedge CLK); #1;
    endtask

    task automatic test_abort();
        logic [7:0] q[$];
        string so, se;
        clear_obs();
        @(posedge CLK); #1; _CS = 1'b0;
        repeat (2) @(posedge CLK); #1;
        ByteValid = 1'b1; RxByte = 8'h03;
        @(posedge CLK); #1; ByteValid = 1'b0;
        repeat (3) @(posedge CLK); #1;
        _CS = 1'b1;
        @(posedge CLK); #1;
        n_cmp++;
        if (Busy !== 1'b0 || wr_obs.size() + rd_obs.size() + tx_obs.size() !== 0) begin
            n_fail++; $display("FAIL abort_idle: got busy=%b strobes=%0d want busy=0 strobes=0",
                               Busy, wr_obs.size() + rd_obs.size() + tx_obs.size());
        end
        repeat (2) @(posedge CLK); #1;
        q = {8'h02, 8'h7E};
        model_txn(q); run_txn(q, 1'b1);
        so = sig(wr_obs, rd_obs, tx_obs, ErrFlag); se = sig(exp_wr, exp_rd, exp_tx, exp_err);
        n_cmp++;
        if (so != se) begin n_fail++; $display("FAIL abort_cs_rise_write: got %s want %s", so, se); end
        q = {8'h84};
        model_txn(q); run_txn(q, 1'b1);
        so = sig(wr_obs, rd_obs, tx_obs, ErrFlag); se = sig(exp_wr, exp_rd, exp_tx, exp_err);
        n_cmp++;
        if (so != se) begin n_fail++; $display("FAIL abort_cs_rise_read: got %s want %s", so, se); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        string so, se;
        for (int t = 0; t < 40; t++) begin
            q.delete();
            q.push_back({1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom_range(0, 13))});
            for (int k = 0; k < int'($urandom_range(0, 4)); k++) q.push_back(8'($urandom));
            model_txn(q); run_txn(q, 1'($urandom_range(0, 1)));
            so = sig(wr_obs, rd_obs, tx_obs, ErrFlag); se = sig(exp_wr, exp_rd, exp_tx, exp_err);
            n_cmp++;
            if (so != se) begin
                n_fail++; $display("FAIL random_txn%0d cmd=%h: got %s want %s", t, q[0], so, se);
            end
        end
        n_cmp++;
        if (both_seen !== 1'b0) begin
            n_fail++; $display("FAIL strobe_exclusive: got both strobes high together, want never");
        end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        test_reset();
        test_write();
        test_read();
        test_burst();
        test_illegal();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
